// File: rtl/state_prep_if.sv
// Request/state handshake bundle for state_prep: basis request in, prepared amplitude vector out.
// master = requester/consumer side, slave = state_prep side.
interface state_prep_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_index;
    logic        req_superpos;
    logic [31:0] state_real_flat;
    logic        state_valid;
    logic        state_ready;
    logic        busy;

    modport master (
        output req_valid, req_index, req_superpos, state_ready,
        input  req_ready, state_real_flat, state_valid, busy
    );

    modport slave (
        input  req_valid, req_index, req_superpos, state_ready,
        output req_ready, state_real_flat, state_valid, busy
    );
endinterface

// File: rtl/state_prep.sv
// Basis-state preparation: builds a 4x8-bit amplitude vector one lane per cycle, state valid 4 cycles after accept.
// Holds the state until state_ready; one IDLE cycle between requests. Optional STATE_PREP_SUPERPOS_EN adds equal superposition.
module state_prep #(
    parameter logic [7:0] AMP_ONE  = 8'd127,
    parameter logic [7:0] AMP_ZERO = 8'd0
) (
    input  logic         clk,
    input  logic         rst_n,
    state_prep_if.slave  bus
);
    // Amplitudes are sign-magnitude style with bit 7 as sign; prepared values are never negative.
    localparam logic [7:0] ONE_C  = AMP_ONE[7] ? 8'h7F : AMP_ONE;
    localparam logic [7:0] ZERO_C = {1'b0, AMP_ZERO[6:0]};
`ifdef STATE_PREP_SUPERPOS_EN
    localparam logic [7:0] HALF_C = ONE_C >> 1;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    state_t      state_q, state_d;
    logic [1:0]  lane_q;
    logic [1:0]  idx_q;
    logic [31:0] shadow_q;
    logic [31:0] flat_q;
    logic        valid_q;
    logic [7:0]  lane_val;
    logic        accept;
    logic        last_lane;
    logic        done;
`ifdef STATE_PREP_SUPERPOS_EN
    logic        sup_q;
`endif

    always_comb begin
        lane_val = (lane_q == idx_q) ? ONE_C : ZERO_C;
`ifdef STATE_PREP_SUPERPOS_EN
        if (sup_q) lane_val = HALF_C;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        last_lane = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                accept  = 1'b1;
                state_d = LOAD;
            end
            LOAD: if (lane_q == 2'd3) begin
                last_lane = 1'b1;
                state_d   = HOLD;
            end
            HOLD: if (bus.state_ready) begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q   <= 2'd0;
            idx_q    <= 2'd0;
            shadow_q <= 32'h0;
            flat_q   <= 32'h0;
            valid_q  <= 1'b0;
`ifdef STATE_PREP_SUPERPOS_EN
            sup_q    <= 1'b0;
`endif
        end else begin
            if (accept) begin
                idx_q  <= bus.req_index;
                lane_q <= 2'd0;
`ifdef STATE_PREP_SUPERPOS_EN
                sup_q  <= bus.req_superpos;
`endif
            end
            if (state_q == LOAD) begin
                shadow_q[{lane_q, 3'b000} +: 8] <= lane_val;
                if (!last_lane) lane_q <= lane_q + 2'd1;
            end
            // Lane 3 lands in the same edge, so merge it directly into the published copy.
            if (last_lane) begin
                flat_q  <= {lane_val, shadow_q[23:0]};
                valid_q <= 1'b1;
            end
            if (done) valid_q <= 1'b0;
        end
    end

    assign bus.req_ready       = (state_q == IDLE);
    assign bus.busy            = (state_q != IDLE);
    assign bus.state_valid     = valid_q;
    assign bus.state_real_flat = flat_q;
endmodule

// File: tb/tb_state_prep.sv
// Directed bench for state_prep: default amplitudes on one instance, clamped amplitudes on a second.
module tb_state_prep;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc;

    always #5 clk = ~clk;

    state_prep_if b0 ();
    state_prep_if b1 ();

    state_prep dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    state_prep #(.AMP_ONE(8'hC0), .AMP_ZERO(8'h85)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake one request on b0; returns just after the accepting edge.
    task automatic send0(input logic [1:0] idx, input logic sup);
        b0.req_valid    = 1'b1;
        b0.req_index    = idx;
        b0.req_superpos = sup;
        tick();
        b0.req_valid    = 1'b0;
        check("accept_drops_rdy", {31'b0, b0.req_ready}, 32'd0);
        check("accept_busy", {31'b0, b0.busy}, 32'd1);
    endtask

    // Edges until b0.state_valid is seen; 99 on timeout.
    task automatic wait_valid0(output int n);
        n = 99;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (b0.state_valid) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        b0.req_valid = 1'b0; b0.req_index = 2'd0; b0.req_superpos = 1'b0; b0.state_ready = 1'b0;
        b1.req_valid = 1'b0; b1.req_index = 2'd0; b1.req_superpos = 1'b0; b1.state_ready = 1'b0;
        #12;
        check("rst_flat", b0.state_real_flat, 32'h0);
        check("rst_valid", {31'b0, b0.state_valid}, 32'd0);
        check("rst_busy", {31'b0, b0.busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_rel_rdy", {31'b0, b0.req_ready}, 32'd1);

        // Basis index 2, consumer always ready.
        b0.state_ready = 1'b1;
        send0(2'd2, 1'b0);
        wait_valid0(cyc);
        check("t2_latency", cyc, 4);
        check("t2_flat", b0.state_real_flat, 32'h007F0000);
        check("t2_rdy_low", {31'b0, b0.req_ready}, 32'd0);
        tick();
        check("t2_valid_1cyc", {31'b0, b0.state_valid}, 32'd0);
        check("t2_idle_rdy", {31'b0, b0.req_ready}, 32'd1);
        check("t2_idle_busy", {31'b0, b0.busy}, 32'd0);
        check("t2_flat_kept", b0.state_real_flat, 32'h007F0000);

        // Index 0 held by a stalled consumer while a stray request (index 3) is presented.
        b0.state_ready = 1'b0;
        send0(2'd0, 1'b0);
        b0.req_valid = 1'b1;
        b0.req_index = 2'd3;
        wait_valid0(cyc);
        check("t3_latency", cyc, 4);
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_valid", {31'b0, b0.state_valid}, 32'd1);
            check("t3_hold_flat", b0.state_real_flat, 32'h0000007F);
            check("t3_hold_rdy", {31'b0, b0.req_ready}, 32'd0);
            tick();
        end
        b0.req_valid   = 1'b0;
        b0.state_ready = 1'b1;
        tick();
        check("t3_release", {31'b0, b0.state_valid}, 32'd0);
        check("t3_flat_kept", b0.state_real_flat, 32'h0000007F);

        // Back-to-back: index 1 then index 3, requester always valid.
        send0(2'd1, 1'b0);
        b0.req_valid = 1'b1;
        b0.req_index = 2'd1;
        wait_valid0(cyc);
        check("t4a_latency", cyc, 4);
        check("t4a_flat", b0.state_real_flat, 32'h00007F00);
        b0.req_index = 2'd3;
        cyc = 99;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (!b0.req_ready) begin
                cyc = k;
                break;
            end
        end
        // Accept gap is 4 (to valid) + 2 (release edge, then idle accept edge).
        check("t4_gap_after_valid", cyc, 2);
        b0.req_valid = 1'b0;
        wait_valid0(cyc);
        check("t4b_latency", cyc, 4);
        check("t4b_flat", b0.state_real_flat, 32'h7F000000);
        tick();

        // Clamped amplitudes on the second instance.
        b1.state_ready = 1'b1;
        b1.req_valid   = 1'b1;
        b1.req_index   = 2'd2;
        tick();
        b1.req_valid   = 1'b0;
        cyc = 99;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (b1.state_valid) begin
                cyc = i;
                break;
            end
        end
        check("t5_latency", cyc, 4);
        check("t5_clamp_flat", b1.state_real_flat, 32'h057F0505);
        tick();

        // Superposition request with index 1.
        send0(2'd1, 1'b1);
        wait_valid0(cyc);
        check("t6_latency", cyc, 4);
`ifdef STATE_PREP_SUPERPOS_EN
        check("t6_superpos", b0.state_real_flat, 32'h3F3F3F3F);
`else
        check("t6_superpos", b0.state_real_flat, 32'h00007F00);
`endif
        tick();

        // Asynchronous reset while holding a state.
        b0.state_ready = 1'b0;
        send0(2'd3, 1'b0);
        wait_valid0(cyc);
        check("t1_hold_flat", b0.state_real_flat, 32'h7F000000);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_async_flat", b0.state_real_flat, 32'h0);
        check("t1_async_valid", {31'b0, b0.state_valid}, 32'd0);
        check("t1_async_busy", {31'b0, b0.busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("t1_rel_rdy", {31'b0, b0.req_ready}, 32'd1);

        // Asynchronous reset mid-LOAD: the partial state must never appear.
        send0(2'd1, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_load_busy", {31'b0, b0.busy}, 32'd0);
        check("t1_load_flat", b0.state_real_flat, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("t1_load_novalid", {31'b0, b0.state_valid}, 32'd0);
        check("t1_load_noflat", b0.state_real_flat, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
